// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : PS/2 host-to-device transmitter. Inhibits the bus, issues
//                request-to-send, shifts a command byte out on device clocks
//                and samples the device acknowledge bit.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INHIBIT  = 3'd1,
        S_RQST     = 3'd2,
        S_SEND     = 3'd3,
        S_ACK      = 3'd4,
        S_WAITIDLE = 3'd5
    } state_t;

    // Pad synchronizers; c_prev_q holds the previous synchronized clock.
    logic c_meta_q, c_sync_q, c_prev_q;
    logic d_meta_q, d_sync_q;
    logic fe;

    always_ff @(posedge ck) begin
        if (rst) begin
            c_meta_q <= 1'b1;
            c_sync_q <= 1'b1;
            c_prev_q <= 1'b1;
            d_meta_q <= 1'b1;
            d_sync_q <= 1'b1;
        end else begin
            c_meta_q <= ps2c_in;
            c_sync_q <= c_meta_q;
            c_prev_q <= c_sync_q;
            d_meta_q <= ps2d_in;
            d_sync_q <= d_meta_q;
        end
    end

    assign fe = c_prev_q & ~c_sync_q;

    state_t           state_q,   state_d;
    logic [7:0]       din_q,     din_d;
    logic             par_q,     par_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q,  to_cnt_d;
    logic             ps2c_oe_q, ps2c_oe_d;
    logic             ps2d_oe_q, ps2d_oe_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             ack_err_q, ack_err_d;
    logic             timeout_q, timeout_d;
    logic             to_expired;

    assign to_expired = (to_cnt_q == TO_LAST);

    always_comb begin
        state_d   = state_q;
        din_d     = din_q;
        par_d     = par_q;
        bit_cnt_d = bit_cnt_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        ps2c_oe_d = ps2c_oe_q;
        ps2d_oe_d = ps2d_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
        timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // busy_q may still be high for the done/timeout cycle.
                ps2c_oe_d = 1'b0;
                ps2d_oe_d = 1'b0;
                busy_d    = 1'b0;
                ack_err_d = 1'b0;
                bit_cnt_d = '0;
                inh_cnt_d = '0;
                to_cnt_d  = '0;
                if (start && !busy_q) begin
                    din_d     = din;
                    par_d     = ~^din;
                    ps2c_oe_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                inh_cnt_d = inh_cnt_q + 1'b1;
                if (inh_cnt_q == INH_LAST) begin
                    inh_cnt_d = '0;
                    to_cnt_d  = '0;
                    ps2c_oe_d = 1'b0;
                    ps2d_oe_d = 1'b1;
                    state_d   = S_RQST;
                end
            end

            S_RQST, S_SEND, S_ACK, S_WAITIDLE: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (to_expired) begin
                    to_cnt_d  = '0;
                    ps2c_oe_d = 1'b0;
                    ps2d_oe_d = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    case (state_q)
                        S_RQST: begin
                            if (fe) begin
                                bit_cnt_d = 4'd1;
                                ps2d_oe_d = ~din_q[0];
                                state_d   = S_SEND;
                            end
                        end
                        S_SEND: begin
                            // bit_cnt_q counts edges already seen, so it indexes the next bit.
                            if (fe) begin
                                bit_cnt_d = bit_cnt_q + 1'b1;
                                if (bit_cnt_q < 4'd8) begin
                                    ps2d_oe_d = ~din_q[bit_cnt_q[2:0]];
                                end else if (bit_cnt_q == 4'd8) begin
                                    ps2d_oe_d = ~par_q;
                                end else begin
                                    ps2d_oe_d = 1'b0;
                                    state_d   = S_ACK;
                                end
                            end
                        end
                        S_ACK: begin
                            if (fe) begin
                                ack_err_d = d_sync_q;
                                state_d   = S_WAITIDLE;
                            end
                        end
                        default: begin
                            if (c_sync_q && d_sync_q) begin
                                done_d  = 1'b1;
                                state_d = S_IDLE;
                            end
                        end
                    endcase
                end
            end

            default: begin
                ps2c_oe_d = 1'b0;
                ps2d_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q   <= S_IDLE;
            din_q     <= '0;
            par_q     <= 1'b0;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            ps2c_oe_q <= 1'b0;
            ps2d_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            din_q     <= din_d;
            par_q     <= par_d;
            bit_cnt_q <= bit_cnt_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            ps2c_oe_q <= ps2c_oe_d;
            ps2d_oe_q <= ps2d_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            timeout_q <= timeout_d;
        end
    end

    assign ps2c_oe = ps2c_oe_q;
    assign ps2d_oe = ps2d_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_host_tx
//  Description : Directed self-checking bench for ps2_host_tx with an
//                open-drain PS/2 device model (device clock time-scaled).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TO   = 2000;
    localparam int HALF = 20;

    logic       ck = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;
    logic       ps2c_oe, ps2d_oe, busy, done, ack_err, timeout;
    logic       ps2c_line, ps2d_line;

    int tests = 0;
    int fails = 0;
    int n_done = 0;
    int n_timeout = 0;
    logic last_ack = 1'b0;

    assign ps2c_line = ~(ps2c_oe | dev_c_low);
    assign ps2d_line = ~(ps2d_oe | dev_d_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .ck      (ck),
        .rst     (rst),
        .start   (start),
        .din     (din),
        .ps2c_in (ps2c_line),
        .ps2d_in (ps2d_line),
        .ps2c_oe (ps2c_oe),
        .ps2d_oe (ps2d_oe),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err),
        .timeout (timeout)
    );

    always #5 ck = ~ck;

    always @(negedge ck) begin
        if (done === 1'b1) begin
            n_done++;
            last_ack = ack_err;
        end
        if (timeout === 1'b1) n_timeout++;
    end

    // Pulse start and count the cycles the clock line is inhibited.
    task automatic launch(input logic [7:0] b, output int inh);
        int n;
        din = b;
        start = 1'b1;
        @(negedge ck);
        start = 1'b0;
        n = 0;
        while (ps2c_oe !== 1'b1 && n < 100) begin
            @(negedge ck);
            n++;
        end
        inh = 0;
        while (ps2c_oe === 1'b1 && inh < 10000) begin
            @(negedge ck);
            inh++;
        end
    endtask

    // Device model: clocks up to 11 pulses, samples line at end of each low phase.
    task automatic dev_frame(input logic do_ack, input int stop_after, input int inj_at,
                             output logic [9:0] bits, output logic ok);
        int n;
        bits = '0;
        ok = 1'b0;
        n = 0;
        while (!(ps2d_oe === 1'b1 && ps2c_oe === 1'b0) && n < 100) begin
            @(negedge ck);
            n++;
        end
        if (n >= 100) return;
        repeat (HALF) @(negedge ck);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && do_ack) begin
                dev_d_low = 1'b1;
                repeat (4) @(negedge ck);
            end
            dev_c_low = 1'b1;
            for (int j = 0; j < HALF; j++) begin
                @(negedge ck);
                start = (k == inj_at && j == HALF / 2);
                if (start) din = 8'hFF;
            end
            if (k <= 10) bits[k-1] = ps2d_line;
            if (k == stop_after) begin
                ok = 1'b1;
                return;
            end
            dev_c_low = 1'b0;
            repeat (HALF) @(negedge ck);
            dev_d_low = 1'b0;
        end
        ok = 1'b1;
    endtask

    task automatic test_reset;
        logic [5:0] obs;
        rst = 1'b1;
        repeat (3) @(negedge ck);
        obs = {ps2c_oe, ps2d_oe, busy, done, ack_err, timeout};
        tests++;
        if (obs !== 6'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected 000000", obs);
        end
        rst = 1'b0;
        repeat (5) @(negedge ck);
        obs = {ps2c_oe, ps2d_oe, busy, done, ack_err, timeout};
        tests++;
        if (obs !== 6'b0) begin
            fails++;
            $display("FAIL idle_outputs: got %b expected 000000", obs);
        end
    endtask

    task automatic test_ack_ed;
        int inh, d0;
        logic [9:0] bits;
        logic ok;
        d0 = n_done;
        launch(8'hED, inh);
        tests++;
        if (inh != INH) begin
            fails++;
            $display("FAIL ed_inhibit_len: got %0d expected %0d", inh, INH);
        end
        dev_frame(1'b1, 0, 0, bits, ok);
        tests++;
        if (ok !== 1'b1) begin
            fails++;
            $display("FAIL ed_rqst_seen: got %b expected 1", ok);
        end
        tests++;
        if (bits[7:0] !== 8'hED) begin
            fails++;
            $display("FAIL ed_data: got %h expected ed", bits[7:0]);
        end
        tests++;
        if (bits[9:8] !== 2'b11) begin
            fails++;
            $display("FAIL ed_parity_stop: got %b expected 11", bits[9:8]);
        end
        repeat (40) @(negedge ck);
        tests++;
        if (n_done - d0 != 1) begin
            fails++;
            $display("FAIL ed_done_count: got %0d expected 1", n_done - d0);
        end
        tests++;
        if (last_ack !== 1'b0) begin
            fails++;
            $display("FAIL ed_ack_err: got %b expected 0", last_ack);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL ed_busy_after: got %b expected 0", busy);
        end
    endtask

    task automatic test_no_ack;
        int inh, d0;
        logic [9:0] bits;
        logic ok;
        d0 = n_done;
        launch(8'h00, inh);
        dev_frame(1'b0, 0, 0, bits, ok);
        tests++;
        if (bits !== 10'b11_0000_0000) begin
            fails++;
            $display("FAIL noack_bits: got %b expected 1100000000", bits);
        end
        repeat (40) @(negedge ck);
        tests++;
        if (n_done - d0 != 1) begin
            fails++;
            $display("FAIL noack_done_count: got %0d expected 1", n_done - d0);
        end
        tests++;
        if (last_ack !== 1'b1) begin
            fails++;
            $display("FAIL noack_ack_err: got %b expected 1", last_ack);
        end
    endtask

    task automatic test_timeout;
        int inh, n, d0, t0;
        d0 = n_done;
        t0 = n_timeout;
        launch(8'h5A, inh);
        tests++;
        if (ps2d_oe !== 1'b1) begin
            fails++;
            $display("FAIL to_rqst_entry: ps2d_oe got %b expected 1", ps2d_oe);
        end
        n = 0;
        while (timeout !== 1'b1 && n < TO + 100) begin
            @(negedge ck);
            n++;
        end
        tests++;
        if (n != TO) begin
            fails++;
            $display("FAIL to_latency: got %0d expected %0d", n, TO);
        end
        tests++;
        if ({ps2c_oe, ps2d_oe} !== 2'b00) begin
            fails++;
            $display("FAIL to_release: got %b expected 00", {ps2c_oe, ps2d_oe});
        end
        repeat (20) @(negedge ck);
        tests++;
        if (n_done != d0 || n_timeout - t0 != 1) begin
            fails++;
            $display("FAIL to_pulses: done %0d timeout %0d expected 0 and 1", n_done - d0, n_timeout - t0);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL to_busy_after: got %b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        int inh, d0;
        logic [9:0] bits;
        logic ok;
        d0 = n_done;
        launch(8'hA5, inh);
        dev_frame(1'b1, 0, 4, bits, ok);
        tests++;
        if (bits !== 10'b11_1010_0101) begin
            fails++;
            $display("FAIL b2b_bits: got %b expected 1110100101", bits);
        end
        repeat (200) @(negedge ck);
        tests++;
        if (n_done - d0 != 1) begin
            fails++;
            $display("FAIL b2b_done_count: got %0d expected 1", n_done - d0);
        end
        tests++;
        if ({ps2c_oe, busy} !== 2'b00) begin
            fails++;
            $display("FAIL b2b_no_restart: oe/busy got %b expected 00", {ps2c_oe, busy});
        end
    endtask

    task automatic test_rst_midframe;
        int inh, d0, t0;
        logic [9:0] bits;
        logic ok;
        d0 = n_done;
        t0 = n_timeout;
        launch(8'hED, inh);
        dev_frame(1'b1, 5, 0, bits, ok);
        rst = 1'b1;
        @(negedge ck);
        tests++;
        if ({ps2c_oe, ps2d_oe, busy} !== 3'b000) begin
            fails++;
            $display("FAIL rst_mid_release: got %b expected 000", {ps2c_oe, ps2d_oe, busy});
        end
        rst = 1'b0;
        dev_c_low = 1'b0;
        dev_d_low = 1'b0;
        repeat (10) @(negedge ck);
        tests++;
        if (n_done != d0 || n_timeout != t0) begin
            fails++;
            $display("FAIL rst_mid_pulses: done %0d timeout %0d expected 0 and 0", n_done - d0, n_timeout - t0);
        end
        launch(8'hF4, inh);
        dev_frame(1'b1, 0, 0, bits, ok);
        tests++;
        if (bits !== 10'b10_1111_0100) begin
            fails++;
            $display("FAIL f4_bits: got %b expected 1011110100", bits);
        end
        repeat (40) @(negedge ck);
        tests++;
        if (n_done - d0 != 1 || last_ack !== 1'b0) begin
            fails++;
            $display("FAIL f4_done: count %0d ack_err %b expected 1 and 0", n_done - d0, last_ack);
        end
    endtask

    initial begin
        test_reset();
        test_ack_ed();
        test_no_ack();
        test_timeout();
        test_back_to_back();
        test_rst_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
